// File: rtl/systolic_drain_if.sv
// Result stream from the drain FIFO head towards the write-back path.
//
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// producer holds out_data, out_col and out_last stable. out_valid never
// depends combinationally on out_ready. When out_valid is low the payload
// signals carry no meaning.
interface systolic_drain_if #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 4,
    parameter int COL_W     = 2
);
    logic                              out_valid;
    logic                              out_ready;
    logic [VECTOR-1:0][REG_WIDTH-1:0]  out_data;
    logic [COL_W-1:0]                  out_col;
    logic                              out_last;

    // Drain side: produces beats.
    modport master (
        output out_valid,
        output out_data,
        output out_col,
        output out_last,
        input  out_ready
    );

    // Write-back side: consumes beats.
    modport slave (
        input  out_valid,
        input  out_data,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_drain.sv
// De-skewing drain for the bottom row of the vector-MAC systolic array.
// A tile start launches a countdown of LATENCY cycles; then one column per
// cycle is sampled from c_in (column j one cycle after column j-1) and pushed
// into a first-word-fall-through FIFO that feeds the write-back stream.
// FIFO space for a whole tile is reserved when the start is accepted, so the
// capture pushes never need to check for a full FIFO.
module systolic_drain #(
    parameter int REG_WIDTH  = 16,
    parameter int VECTOR     = 4,
    parameter int COLS       = 4,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int FC_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 start_ready,
    input  logic [REG_WIDTH-1:0] c_in [COLS-1:0][VECTOR-1:0],
    output logic                 busy,
    output logic                 tile_done,
    output logic [FC_W-1:0]      fifo_count,
    output logic [1:0]           dbg_state,
    systolic_drain_if.master     out_bus
);

    localparam int MAXC   = (LATENCY > COLS) ? LATENCY : COLS;
    localparam int CNT_W  = $clog2(MAXC + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FREE_W = FC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic                             last;
        logic [COL_W-1:0]                 col;
        logic [VECTOR-1:0][REG_WIDTH-1:0] data;
    } entry_t;

    // Control state. In WAIT the counter holds cycles since acceptance; in
    // CAPTURE it holds the index of the column sampled at the next edge.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tile_done_q, tile_done_d;

    // Capture decode.
    logic              capture;
    logic [COL_W-1:0]  cap_col;
    logic              cap_last;
    entry_t            push_entry;

    // FIFO storage and bookkeeping.
    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [PTR_W-1:0]  wr_nxt, rd_nxt;
    logic [FC_W-1:0]   count_q;
    logic [FREE_W-1:0] free_slots;
    logic              push, pop;
    logic              head_valid;
    entry_t            head;

    // Free space seen by the start check; a whole tile must fit.
    assign free_slots = FREE_W'(FIFO_DEPTH) - {1'b0, count_q};

    // FSM state register with counter and the tile_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    // FSM next-state: count out the array latency, then walk the columns.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && start_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (capture) begin
                    if (cap_last) begin
                        // Single-column array: the first capture ends the tile.
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        tile_done_d = 1'b1;
                    end else begin
                        state_d = S_CAPTURE;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                if (cap_last) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    tile_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: acceptance, busy flag and which column is sampled now.
    always_comb begin
        busy        = (state_q != S_IDLE);
        start_ready = (state_q == S_IDLE) && (free_slots >= FREE_W'(COLS));
        capture     = 1'b0;
        cap_col     = '0;
        if ((state_q == S_WAIT) && (cnt_q == CNT_W'(LATENCY))) begin
            capture = 1'b1;
            cap_col = '0;
        end else if (state_q == S_CAPTURE) begin
            capture = 1'b1;
            cap_col = COL_W'(cnt_q);
        end
        cap_last = capture && (cap_col == COL_W'(COLS - 1));
    end

    // Select the column being sampled and tag it with its index.
    always_comb begin
        push_entry.last = cap_last;
        push_entry.col  = cap_col;
        for (int v = 0; v < VECTOR; v++) begin
            push_entry.data[v] = c_in[cap_col][v];
        end
    end

    assign push       = capture;
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && out_bus.out_ready;
    assign wr_nxt     = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    assign rd_nxt     = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);

    // FIFO storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_q] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_nxt;
            end
            if (pop) begin
                rd_q <= rd_nxt;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + FC_W'(1);
                2'b01:   count_q <= count_q - FC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head of the FIFO falls through to the stream; payload zeroed when empty.
    always_comb begin
        head              = mem_q[rd_q];
        out_bus.out_valid = head_valid;
        out_bus.out_data  = head_valid ? head.data : '0;
        out_bus.out_col   = head_valid ? head.col  : '0;
        out_bus.out_last  = head_valid ? head.last : 1'b0;
    end

    assign tile_done  = tile_done_q;
    assign fifo_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Collects results from the bottom row of the vector-MAC systolic array (COLS columns, each emitting a VECTOR-lane accumulator word) and de-skews them.
- Column j's result appears one cycle after column j-1. The block samples each column at its own cycle and queues the words in an internal FIFO.
- Streams the queued words to the write-back path over a valid/ready interface.
- Sits between the array's c outputs and the result buffer, and is the reading end of the array's c-propagation chain.

Parameters:
- REG_WIDTH, 16, width of one lane.
- VECTOR, 4, lanes per column word.
- COLS, 4, number of array columns drained per tile.
- LATENCY, 4, cycles from tile start acceptance to column 0 result valid on c_in[0]. Must be >= 1.
- FIFO_DEPTH, 8, output FIFO entries. Must be >= COLS.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to drain one tile.
- start_ready  out  1  high when a start is accepted this cycle.
- c_in  in  COLS x VECTOR x REG_WIDTH (unpacked [COLS-1:0][VECTOR-1:0])  bottom-row array results.
- busy  out  1  tile in progress (state != IDLE).
- tile_done  out  1  one-cycle pulse after the last column is captured.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  VECTOR x REG_WIDTH  head column word.
- out_col  out  clog2(COLS) (min 1)  column index of head word.
- out_last  out  1  head is column COLS-1 of its tile.
- fifo_count  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset, synchronous, has priority over all other inputs:
  - state=IDLE, counter=0, FIFO emptied.
  - out_valid=0, out_data=0, out_col=0, out_last=0, tile_done=0, fifo_count=0.
  - An in-flight tile is discarded; no further captures occur.
  - start_ready=1 in the cycle after reset deasserts.
- start_ready = (state==IDLE) && (FIFO_DEPTH - fifo_count >= COLS). It is combinational. start while start_ready=0 is ignored; no queuing of requests.
- FSM states:
  - IDLE: on start && start_ready at edge E0, go to WAIT, counter=1.
  - WAIT: counter increments each cycle. When counter==LATENCY at an edge, capture column 0 and go to CAPTURE.
  - CAPTURE: at edge E0+LATENCY+j, sample c_in[j][*] and push {data, col=j, last=(j==COLS-1)}. After the j=COLS-1 push, go to IDLE and pulse tile_done for one cycle.
- Cycle-level timing:
  - Total tile occupancy is LATENCY+COLS cycles.
  - A new start is acceptable the cycle tile_done is high.
- Space is reserved at acceptance, so pushes during a tile never overflow; pops only add space. Pushes are unconditional.
- FIFO behaviour:
  - Registered, first-word-fall-through.
  - A word pushed at edge E is visible on out_data with out_valid=1 after E, if the FIFO was empty.
  - Pop occurs at an edge where out_valid && out_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; non-power-of-2 depth is supported.
- Output stability: while out_valid && !out_ready, out_data, out_col and out_last hold stable.
- When the FIFO is empty: out_valid=0, and out_data/out_col/out_last are don't-care.
- Arithmetic: lane data is passed through unmodified; no truncation or sign handling.
- c_in is ignored outside capture cycles.

Test Plan:
- Basic tile (defaults): start at cycle 0 with c_in[j][v]=16'h0100*j+v held. Required:
  - words for col 0..3 pushed at edges 4..7;
  - out_valid rises after edge 4;
  - beats {0x0000,0x0001,0x0002,0x0003} col0 through {0x0300..0x0303} col3 with out_last on col3;
  - tile_done high the cycle after edge 7.
- De-skew check: drive c_in[j] with a valid pattern only at cycle 4+j, garbage otherwise. Required: only the pattern words appear, in column order.
- Backpressure and reservation: out_ready=0, two tiles back-to-back.
  - After the first tile fifo_count=4; second start accepted (free=4); fifo_count=8.
  - Third start: start_ready=0 and the start is ignored.
  - Release out_ready: 8 beats in order, then start_ready=1.
- Start while busy: assert start continuously. Required: exactly one tile per LATENCY+COLS cycles, and start_ready=0 while busy.
- Reset mid-tile: assert rst at edge E0+LATENCY+1 (after col 0 pushed). Required:
  - fifo_count=0, out_valid=0, busy=0 next cycle;
  - no col1..3 pushes; no tile_done.
- Simultaneous push/pop: out_ready=1 throughout a tile. Required:
  - fifo_count stays at most 1;
  - each word appears one cycle after capture;
  - no word is lost or duplicated.
